// File: rtl/serial_pkg.sv
// Shared definitions for the serial path: the serializer FSM encoding and the
// default word width, reused by the downstream detector stages.
package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/skid_reg1.sv
// One-entry holding register that parks the next word while the shifter is busy.
module skid_reg1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             full;
  logic [WIDTH-1:0] data;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // ready depends only on registered state, and a held word never changes until popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (out_valid && out_ready) begin
      full <= 1'b0;
    end else if (in_valid && in_ready) begin
      full <= 1'b1;
      data <= in_data;
    end
  end

  assign in_ready  = !full;
  assign out_valid = full;
  assign out_data  = data;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a one-word holding stage so that
// consecutive words stream with no idle cycles between them.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy,
  output logic             dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] hold_data;
  logic [CW-1:0]    bit_cnt;
  logic             last_bit;
  logic             accept;
  logic             hold_valid;
  logic             hold_ready;
  logic             hold_push;

  assign last_bit = (state == SHIFT) && (bit_cnt == LAST);
  assign accept   = data_valid && data_ready;
  // Words arriving mid-word are parked; on the last bit they bypass into the shifter.
  assign hold_push = data_valid && (state == SHIFT) && !last_bit;

  skid_reg1 #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (hold_push),
    .in_ready  (hold_ready),
    .in_data   (data_in),
    .out_valid (hold_valid),
    .out_ready (last_bit),
    .out_data  (hold_data)
  );

  always_comb begin
    if (MSB_FIRST != 0) shift_nxt = {shift_reg[WIDTH-2:0], 1'b0};
    else                shift_nxt = {1'b0, shift_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg <= data_in;
            bit_cnt   <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            bit_cnt <= '0;
            if (hold_valid) begin
              shift_reg <= hold_data;
            end else if (accept) begin
              shift_reg <= data_in;
            end else begin
              shift_reg <= shift_nxt;
              state     <= IDLE;
            end
          end else begin
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign data_ready = hold_ready;
  assign ser_valid  = (state == SHIFT);
  assign ser_out    = (state == SHIFT) &&
                      ((MSB_FIRST != 0) ? shift_reg[WIDTH-1] : shift_reg[0]);
  assign word_done  = last_bit;
  assign busy       = (state == SHIFT) || hold_valid;
  assign dbg_state  = state;

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: word width in bits, legal range 2..16.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 first, 0 = bit 0 first.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port data_in, input, WIDTH bits: parallel word to serialize.
REQ-006 SHALL have port data_valid, input, 1 bit: data_in holds a word offered by the producer.
REQ-007 SHALL have port data_ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 SHALL have port ser_out, output, 1 bit: serial bit feeding the downstream sequence detector.
REQ-009 SHALL have port ser_valid, output, 1 bit: ser_out carries a payload bit.
REQ-010 SHALL have port word_done, output, 1 bit: one-cycle pulse during the last bit of each word.
REQ-011 SHALL have port busy, output, 1 bit: the shifter or the holding register is occupied.

Function
REQ-012 SHALL accept a word on a rising edge where data_valid=1 and data_ready=1; the producer holds data_in stable while data_valid=1 and data_ready=0.
REQ-013 SHALL provide two storage stages: a shift register and a one-entry holding register; data_ready = NOT hold_full (combinational from registered state only).
REQ-014 SHALL implement FSM states IDLE and SHIFT.
REQ-015 IDLE: ser_valid=0, ser_out=0. On accept, load the shift register directly, clear bit_cnt, and go to SHIFT.
REQ-016 SHIFT: ser_valid=1. ser_out = shift_reg[WIDTH-1] when MSB_FIRST=1, shift_reg[0] otherwise.
REQ-017 SHIFT, each edge: shift by one toward the output end, zero-fill, bit_cnt+1.
REQ-018 Last bit (bit_cnt=WIDTH-1): word_done=1; on the next edge:
- holding register full: move it into the shifter, clear hold_full, stay in SHIFT.
- else accept this cycle: load data_in directly into the shifter, stay in SHIFT.
- else: go to IDLE.
REQ-019 An accept in SHIFT before the last bit SHALL write the holding register.
REQ-020 Latency: the first bit appears on ser_out in the cycle after the accepting edge; consecutive words stream with zero idle cycles.
REQ-021 Last bit with hold full and an offered word: data_ready=0, so no accept occurs; the offered word is taken on the next edge.
REQ-022 bit_cnt SHALL be $clog2(WIDTH) bits wide and return to 0 after WIDTH-1; no other wrap value.
REQ-023 busy = (state==SHIFT) OR hold_full.

Reset
REQ-024 rst=1 SHALL immediately force: state=IDLE, shift_reg=0, bit_cnt=0, hold_full=0, holding register=0.
REQ-025 During reset, outputs SHALL be: ser_out=0, ser_valid=0, word_done=0, busy=0, data_ready=1.
REQ-026 Reset asserted mid-word SHALL discard the partial word and any held word; no bit SHALL be emitted after rst deasserts until a new accept.

Structure
REQ-027 FSM state encodings and the default WIDTH SHALL reside in a shared package serial_pkg, reused by the detector stages.
REQ-028 The holding register plus hold_full SHALL be one sub-module, skid_reg1, with a valid/ready in/out interface; the FSM, shifter and counter stay in the top module.

Verification
REQ-029 Reset then a single word: accept 8'hDB (11011011), MSB_FIRST=1 -> ser_out 1,1,0,1,1,0,1,1 over 8 cycles; word_done in cycle 8; IDLE in cycle 9.
REQ-030 Back-to-back: 8'hD8 then 8'h1B held valid -> 16 contiguous ser_valid cycles; second word goes to hold; data_ready=0 from the cycle after the second accept until the first word's last-bit edge.
REQ-031 Hold full plus a third offer: data_valid held high -> third word not accepted until hold empties; no bit lost or duplicated; 24 contiguous bits.
REQ-032 LSB-first: MSB_FIRST=0, accept 8'h1B -> ser_out 1,1,0,1,1,0,0,0.
REQ-033 Reset mid-operation: rst=1 at bit 4 of 8'hFF with hold full -> ser_valid=0, busy=0, data_ready=1 immediately; zero bits after release.
REQ-034 End-to-end with the downstream 11011 detector: stream 8'hDB -> detector output pulses exactly once.
